exe_stage_mc: RTL and testbench
===============================

// Module: exe_stage_mc
// PURPOSE
//  Parametrised multi-cycle execute stage; successor to the single-cycle execute stage.
//  Sits between ID/EX and MEM.
//  - Takes operands from N forwarding sources.
//  - Single-cycle ALU ops, plus an iterative MUL.
//  - Owns the EX/MEM output register, with valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W    32  operand/result width
//  ADDR_W    32  PC / branch address width
//  REG_AW     4  destination register address width
//  FWD_N      2  number of forwarding sources (>=1)
//  MUL_BPC    1  multiplier bits per cycle; DATA_W % MUL_BPC == 0
// PORTS
//  clk           in   1               clock, rising edge
//  rst           in   1               synchronous reset, active-high
//  flush         in   1               kill in-flight and held op (branch mispredict)
//  in_valid      in   1               ID/EX presents an op
//  in_ready      out  1               stage accepts op this cycle
//  pc_in         in   ADDR_W          PC of op
//  ctl_in        in   5               {wb_en,mem_r,mem_w,status_w,branch}
//  exe_cmd       in   4               operation code (see BEHAVIOUR)
//  immd          in   1               operand2 is immediate
//  shift_op      in   12              immediate / memory offset
//  imm24         in   24              branch offset, in words
//  val_rn        in   DATA_W          register-file Rn
//  val_rm        in   DATA_W          register-file Rm
//  sel_rn        in   $clog2(FWD_N+1) 0 = val_rn, k = fwd_data slice k-1
//  sel_rm        in   $clog2(FWD_N+1) as sel_rn, for Rm
//  fwd_data      in   FWD_N*DATA_W    forwarded values; slice k-1 at [k*DATA_W-1 -: DATA_W]
//  dest_in       in   REG_AW          destination register
//  status_in     in   4               {N,Z,C,V} from status register
//  out_valid     out  1               EX/MEM register holds valid op
//  out_ready     in   1               MEM consumes op
//  ctl_out       out  5               registered ctl_in
//  dest_out      out  REG_AW          registered dest_in
//  alu_res       out  DATA_W          result
//  rm_out        out  DATA_W          forwarded Rm (store data)
//  status_out    out  4               new {N,Z,C,V}
//  branch_addr   out  ADDR_W          pc + sext(imm24)<<2, truncated to ADDR_W
// BEHAVIOUR
//  Reset:
//   - all outputs 0, state IDLE, counter 0.
//   - in_ready = 0 during rst; asserts on the first cycle after rst.
//  in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
//  Accept = in_valid & in_ready. At accept, operands are captured after forwarding muxes.
//  sel values above FWD_N select 0.
//  op2:
//   - if mem_r|mem_w: zero-extended shift_op[11:0];
//   - else if immd: zero-extended shift_op[7:0];
//   - else: Rm.
//  Commands (res, flags):
//   - 0001 MOV op2;  1001 MVN ~op2.
//   - 0010 ADD;  0011 ADC (+C);  0100 SUB;  0101 SBC (-~C).
//   - 0110 AND;  0111 ORR;  1000 EOR.
//   - 1010 MUL: low DATA_W bits of Rn*op2.
//   - others: res 0.
//  Flags:
//   - N = res[MSB]; Z = (res==0).
//   - Add/sub: C = carry-out (SUB: no borrow); V = signed overflow.
//   - Logic/MOV/MUL: C and V taken from status_in.
//  FSM IDLE/MUL:
//   - IDLE, accept non-MUL: EX/MEM register loads at the next edge; out_valid=1 (latency 1).
//   - IDLE, accept MUL: -> MUL, cnt = DATA_W/MUL_BPC.
//     Each cycle: shift-add MUL_BPC multiplier bits, cnt--.
//     When cnt reaches 1: load EX/MEM, out_valid=1, -> IDLE.
//     Latency is DATA_W/MUL_BPC cycles.
//  Output hold:
//   - while out_valid & ~out_ready, all outputs hold stable.
//   - out_valid clears on out_ready unless a new op loads in the same cycle.
//  Back-to-back: out_ready=1 with continuous in_valid gives 1 op/cycle for non-MUL ops.
//  Flush (sync, beats everything):
//   - next cycle: out_valid=0, state IDLE, cnt=0.
//   - no accept in the flush cycle.
//   - ctl_out cleared to 0.
//  Reset mid-MUL: abandons the op, same as a flush, with all outputs also zeroed.
// TESTING
//  1. ADD 0x7FFFFFFF+1, sel 0 -> next cycle alu_res=0x80000000, status_out N=1,Z=0,C=0,V=1.
//  2. SUB Rn=5, Rm via fwd slice 1 =5 (sel_rm=2) -> alu_res=0, Z=1, C=1.
//  3. MUL 0x10001*0x10001, MUL_BPC=1 -> in_ready=0 for 31 cycles;
//     out_valid on cycle 32; alu_res=0x00020001.
//  4. out_ready=0 for 3 cycles with op held -> outputs stable, in_ready=0;
//     next op accepted the cycle out_ready=1.
//  5. flush at MUL cycle 10 -> next cycle out_valid=0, in_ready=1; next ADD completes in 1 cycle.
//  6. branch imm24=0xFFFFFF, pc_in=0x100 -> branch_addr=0xFC; rst mid-op -> all outputs 0.

Source files
------------

// File: rtl/exe_stage_mc_if.sv
// exe_stage_mc_if: ID/EX-side and EX/MEM-side signal bundle of the multi-cycle execute stage
interface exe_stage_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 4,
  parameter int FWD_N  = 2
);
  localparam int SW = $clog2(FWD_N + 1);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_W-1:0]       pc_in;
  logic [4:0]              ctl_in;
  logic [3:0]              exe_cmd;
  logic                    immd;
  logic [11:0]             shift_op;
  logic [23:0]             imm24;
  logic [DATA_W-1:0]       val_rn;
  logic [DATA_W-1:0]       val_rm;
  logic [SW-1:0]           sel_rn;
  logic [SW-1:0]           sel_rm;
  logic [FWD_N*DATA_W-1:0] fwd_data;
  logic [REG_AW-1:0]       dest_in;
  logic [3:0]              status_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [4:0]              ctl_out;
  logic [REG_AW-1:0]       dest_out;
  logic [DATA_W-1:0]       alu_res;
  logic [DATA_W-1:0]       rm_out;
  logic [3:0]              status_out;
  logic [ADDR_W-1:0]       branch_addr;
  modport master (
    output flush, in_valid, pc_in, ctl_in, exe_cmd, immd, shift_op, imm24, val_rn, val_rm,
           sel_rn, sel_rm, fwd_data, dest_in, status_in, out_ready,
    input  in_ready, out_valid, ctl_out, dest_out, alu_res, rm_out, status_out, branch_addr
  );
  modport slave (
    input  flush, in_valid, pc_in, ctl_in, exe_cmd, immd, shift_op, imm24, val_rn, val_rm,
           sel_rn, sel_rm, fwd_data, dest_in, status_in, out_ready,
    output in_ready, out_valid, ctl_out, dest_out, alu_res, rm_out, status_out, branch_addr
  );
endinterface

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: multi-cycle execute stage with forwarding muxes, single-cycle ALU, iterative MUL and EX/MEM register
module exe_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 4,
  parameter int FWD_N   = 2,
  parameter int MUL_BPC = 1
) (
  input logic clk,
  input logic rst,
  exe_stage_mc_if.slave b
);
  localparam int SW = $clog2(FWD_N + 1);
  localparam int CNT_N = DATA_W / MUL_BPC;
  localparam int CW = $clog2(CNT_N + 1);
  localparam logic [3:0] MUL_CMD = 4'b1010;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rn, rm, op2, b2, res, mcand, mplier, acc, acc_nx, prod, h_rm;
  logic [DATA_W:0] sum;
  logic [ADDR_W+25:0] boff;
  logic [ADDR_W-1:0] br, h_br;
  logic [REG_AW-1:0] h_dest;
  logic [4:0] h_ctl;
  logic [1:0] h_cv;
  logic is_add, is_sub, cin, c, v, accept, is_mul, mul_done, load;
  function automatic logic [DATA_W-1:0] pick(input logic [SW-1:0] s, input logic [DATA_W-1:0] rf,
                                             input logic [FWD_N*DATA_W-1:0] fw);
    logic [DATA_W-1:0] r;
    r = s == '0 ? rf : '0;
    for (int k = 1; k <= FWD_N; k++) r = s == SW'(k) ? fw[k*DATA_W-1 -: DATA_W] : r;
    return r;
  endfunction
  assign b.in_ready = state == IDLE && (!b.out_valid || b.out_ready) && !b.flush && !rst;
  assign accept = b.in_valid && b.in_ready;
  assign is_mul = b.exe_cmd == MUL_CMD;
  assign mul_done = state == MUL && cnt == CW'(1) && !b.flush;
  assign load = (accept && !is_mul) || mul_done;
  assign rn = pick(b.sel_rn, b.val_rn, b.fwd_data);
  assign rm = pick(b.sel_rm, b.val_rm, b.fwd_data);
  assign op2 = (b.ctl_in[3] || b.ctl_in[2]) ? DATA_W'(b.shift_op) : b.immd ? DATA_W'(b.shift_op[7:0]) : rm;
  // subtraction is rn + ~op2 + carry, so SUB carries in 1 and SBC carries in C
  assign is_add = b.exe_cmd == 4'b0010 || b.exe_cmd == 4'b0011;
  assign is_sub = b.exe_cmd == 4'b0100 || b.exe_cmd == 4'b0101;
  assign b2 = is_sub ? ~op2 : op2;
  assign cin = b.exe_cmd == 4'b0100 || ((b.exe_cmd == 4'b0011 || b.exe_cmd == 4'b0101) && b.status_in[1]);
  assign sum = {1'b0, rn} + {1'b0, b2} + {{DATA_W{1'b0}}, cin};
  assign c = (is_add || is_sub) ? sum[DATA_W] : b.status_in[1];
  assign v = (is_add || is_sub) ? rn[DATA_W-1] == b2[DATA_W-1] && sum[DATA_W-1] != rn[DATA_W-1] : b.status_in[0];
  always_comb begin
    res = '0;
    case (b.exe_cmd)
      4'b0001: res = op2;
      4'b1001: res = ~op2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: res = sum[DATA_W-1:0];
      4'b0110: res = rn & op2;
      4'b0111: res = rn | op2;
      4'b1000: res = rn ^ op2;
      default: res = '0;
    endcase
  end
  assign prod = mcand * DATA_W'(mplier[MUL_BPC-1:0]);
  assign acc_nx = acc + prod;
  assign boff = {{ADDR_W{b.imm24[23]}}, b.imm24, 2'b00};
  assign br = b.pc_in + boff[ADDR_W-1:0];
  always_comb begin
    state_nx = b.flush || mul_done ? IDLE : accept && is_mul ? MUL : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      h_ctl <= '0;
      h_dest <= '0;
      h_rm <= '0;
      h_cv <= '0;
      h_br <= '0;
      b.out_valid <= 1'b0;
      b.ctl_out <= '0;
      b.dest_out <= '0;
      b.alu_res <= '0;
      b.rm_out <= '0;
      b.status_out <= '0;
      b.branch_addr <= '0;
    end else begin
      state <= state_nx;
      cnt <= b.flush ? '0 : accept && is_mul ? CW'(CNT_N) : state == MUL ? cnt - CW'(1) : cnt;
      if (accept) begin
        h_ctl <= b.ctl_in;
        h_dest <= b.dest_in;
        h_rm <= rm;
        h_cv <= b.status_in[1:0];
        h_br <= br;
        mcand <= rn;
        mplier <= op2;
        acc <= '0;
      end else if (state == MUL) begin
        mcand <= mcand << MUL_BPC;
        mplier <= mplier >> MUL_BPC;
        acc <= acc_nx;
      end
      if (b.flush) begin
        b.out_valid <= 1'b0;
        b.ctl_out <= '0;
      end else if (load) begin
        b.out_valid <= 1'b1;
        b.ctl_out <= mul_done ? h_ctl : b.ctl_in;
        b.dest_out <= mul_done ? h_dest : b.dest_in;
        b.alu_res <= mul_done ? acc_nx : res;
        b.rm_out <= mul_done ? h_rm : rm;
        b.status_out <= mul_done ? {acc_nx[DATA_W-1], acc_nx == '0, h_cv} : {res[DATA_W-1], res == '0, c, v};
        b.branch_addr <= mul_done ? h_br : br;
      end else if (b.out_ready) begin
        b.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed and random checks of exe_stage_mc against a scoreboard of modelled results
module tb_exe_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  exe_stage_mc_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(4), .FWD_N(2)) bus ();
  exe_stage_mc #(.DATA_W(32), .ADDR_W(32), .REG_AW(4), .FWD_N(2), .MUL_BPC(1)) dut (
    .clk(clk),
    .rst(rst),
    .b(bus)
  );
  typedef struct packed {
    logic [4:0]  ctl;
    logic [3:0]  dest;
    logic [31:0] res;
    logic [31:0] rm;
    logic [3:0]  st;
    logic [31:0] br;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int late;
  logic [3:0] cmds [9] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] rf, input logic [63:0] fw);
    case (s)
      2'd0: return rf;
      2'd1: return fw[31:0];
      2'd2: return fw[63:32];
      default: return 32'd0;
    endcase
  endfunction
  function automatic exp_t model();
    exp_t x;
    logic [31:0] a, m, o, r;
    logic [32:0] w;
    logic [63:0] p;
    logic c, v;
    a = fsel(bus.sel_rn, bus.val_rn, bus.fwd_data);
    m = fsel(bus.sel_rm, bus.val_rm, bus.fwd_data);
    o = (bus.ctl_in[3] || bus.ctl_in[2]) ? {20'd0, bus.shift_op} : bus.immd ? {24'd0, bus.shift_op[7:0]} : m;
    c = bus.status_in[1];
    v = bus.status_in[0];
    r = 32'd0;
    case (bus.exe_cmd)
      4'h1: r = o;
      4'h9: r = ~o;
      4'h2, 4'h3: begin
        w = {1'b0, a} + {1'b0, o} + ((bus.exe_cmd == 4'h3 && c) ? 33'd1 : 33'd0);
        r = w[31:0];
        c = w[32];
        v = a[31] == o[31] && r[31] != a[31];
      end
      4'h4, 4'h5: begin
        w = {1'b0, o} + ((bus.exe_cmd == 4'h5 && !c) ? 33'd1 : 33'd0);
        r = a - w[31:0];
        c = {1'b0, a} >= w;
        v = a[31] != o[31] && r[31] != a[31];
      end
      4'h6: r = a & o;
      4'h7: r = a | o;
      4'h8: r = a ^ o;
      4'hA: begin
        p = {32'd0, a} * {32'd0, o};
        r = p[31:0];
      end
      default: r = 32'd0;
    endcase
    x.ctl = bus.ctl_in;
    x.dest = bus.dest_in;
    x.res = r;
    x.rm = m;
    x.st = {r[31], r == 32'd0, c, v};
    x.br = bus.pc_in + {{6{bus.imm24[23]}}, bus.imm24, 2'b00};
    return x;
  endfunction
  always @(negedge clk) begin
    if (rst || bus.flush) sb.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_output observed=%0h expected=none", bus.alu_res);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_res", bus.alu_res, e.res);
          chk("sb_status", bus.status_out, e.st);
          chk("sb_ctl", bus.ctl_out, e.ctl);
          chk("sb_dest", bus.dest_out, e.dest);
          chk("sb_rm", bus.rm_out, e.rm);
          chk("sb_br", bus.branch_addr, e.br);
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model());
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                     input logic [1:0] srn, input logic [1:0] srm, input logic [63:0] fw,
                     input logic im, input logic [11:0] sh, input logic [4:0] ctl);
    bus.exe_cmd = cmd;
    bus.val_rn = rn;
    bus.val_rm = rm;
    bus.sel_rn = srn;
    bus.sel_rm = srm;
    bus.fwd_data = fw;
    bus.immd = im;
    bus.shift_op = sh;
    bus.ctl_in = ctl;
    bus.dest_in = 4'($urandom);
    bus.status_in = 4'($urandom);
    bus.pc_in = $urandom;
    bus.imm24 = 24'($urandom);
    bus.in_valid = 1'b1;
  endtask
  task automatic late_check(input string tag);
    late = 0;
    repeat (40) begin
      cyc();
      if (bus.out_valid) late++;
    end
    chk(tag, late, 0);
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    put(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res", bus.alu_res, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    put(4'h2, 32'h7FFF_FFFF, 32'd1, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    bus.in_valid = 1'b0;
    chk("add_valid", bus.out_valid, 1);
    chk("add_res", bus.alu_res, 32'h8000_0000);
    chk("add_flags", bus.status_out, 4'b1001);
    put(4'h4, 32'd5, 32'hDEAD, 0, 2, {32'd5, 32'd9}, 0, 0, 5'b10010);
    cyc();
    bus.in_valid = 1'b0;
    chk("sub_res", bus.alu_res, 0);
    chk("sub_flags", bus.status_out, 4'b0110);
    chk("sub_rm_fwd", bus.rm_out, 5);
    put(4'h2, 32'h1234, 32'd7, 3, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    chk("sel_oob_res", bus.alu_res, 7);
    put(4'h2, 32'd10, 32'd999, 0, 0, {$urandom, $urandom}, 1, 12'hF23, 5'b10000);
    cyc();
    chk("immd_res", bus.alu_res, 32'h2D);
    put(4'h2, 32'd10, 32'd999, 0, 0, {$urandom, $urandom}, 1, 12'hF23, 5'b01000);
    cyc();
    bus.in_valid = 1'b0;
    chk("memoff_res", bus.alu_res, 32'hF2D);
    for (int i = 0; i < 12; i++) begin
      put(cmds[$urandom_range(0, 8)], $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, 1'($urandom), 12'($urandom), 5'($urandom));
      #1;
      chk("b2b_ready", bus.in_ready, 1);
      cyc();
      chk("b2b_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    cyc();
    put(4'hA, 32'h10001, 32'h10001, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      chk("mul_busy", bus.in_ready, 0);
      cyc();
    end
    chk("mul_not_early", bus.out_valid, 0);
    cyc();
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_res", bus.alu_res, 32'h0002_0001);
    cyc();
    put(4'hA, $urandom, $urandom, 0, 1, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) cyc();
    chk("mul_rand_done", bus.out_valid, 1);
    cyc();
    bus.out_ready = 1'b0;
    put(4'h2, 32'd3, 32'd4, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10001);
    cyc();
    put(4'h2, 32'd1, 32'd1, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_res", bus.alu_res, 7);
      chk("hold_ctl", bus.ctl_out, 5'b10001);
      chk("hold_flags", bus.status_out, 4'b0000);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    chk("release_valid", bus.out_valid, 1);
    chk("release_res", bus.alu_res, 2);
    cyc();
    put(4'hA, $urandom, $urandom, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    bus.in_valid = 1'b0;
    repeat (9) cyc();
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", bus.in_ready, 0);
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ready_after", bus.in_ready, 1);
    chk("flush_ctl", bus.ctl_out, 0);
    put(4'h2, 32'd20, 32'd22, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10000);
    cyc();
    bus.in_valid = 1'b0;
    chk("flush_add_valid", bus.out_valid, 1);
    chk("flush_add_res", bus.alu_res, 42);
    cyc();
    late_check("flush_no_late");
    put(4'h1, 32'd0, 32'd0, 0, 0, {$urandom, $urandom}, 0, 0, 5'b10001);
    bus.pc_in = 32'h100;
    bus.imm24 = 24'hFF_FFFF;
    cyc();
    bus.in_valid = 1'b0;
    chk("branch_addr", bus.branch_addr, 32'hFC);
    cyc();
    put(4'hA, $urandom, $urandom, 0, 0, {$urandom, $urandom}, 0, 0, 5'b11111);
    cyc();
    bus.in_valid = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_ready", bus.in_ready, 0);
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_res", bus.alu_res, 0);
    chk("rst_mid_status", bus.status_out, 0);
    chk("rst_mid_ctl", bus.ctl_out, 0);
    chk("rst_mid_dest", bus.dest_out, 0);
    chk("rst_mid_rm", bus.rm_out, 0);
    chk("rst_mid_br", bus.branch_addr, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", bus.in_ready, 1);
    late_check("rst_no_late");
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
